// File: rtl/microgreen_uart_report_tx.sv
// UART 8N1 transmitter for the 7-byte classifier report frame:
// SYNC_BYTE, payload bytes b0..b4, then the XOR of b0..b4.
module microgreen_uart_report_tx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [39:0] payload,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [1:0]  dbg_state
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [7:0]        shift_q, shift_d;
  logic [39:0]       payload_q, payload_d;
  logic [7:0]        chk_q, chk_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic              baud_end;
  logic [7:0]        next_byte;

  assign baud_end = (baud_q == BAUD_LAST);

  // Byte that follows the one currently indexed by byte_q.
  always_comb begin
    next_byte = chk_q;
    case (byte_q)
      3'd0:    next_byte = payload_q[7:0];
      3'd1:    next_byte = payload_q[15:8];
      3'd2:    next_byte = payload_q[23:16];
      3'd3:    next_byte = payload_q[31:24];
      3'd4:    next_byte = payload_q[39:32];
      default: next_byte = chk_q;
    endcase
  end

  // Handshake: a start pulse is accepted on an enabled edge where busy is low;
  // a start seen while busy is high is dropped and reported on overrun.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    payload_d = payload_q;
    chk_d     = chk_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;

    if (ena) begin
      if (start && busy_q) begin
        overrun_d = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_START;
            payload_d = payload;
            chk_d     = payload[7:0] ^ payload[15:8] ^ payload[23:16]
                      ^ payload[31:24] ^ payload[39:32];
            shift_d   = SYNC_BYTE;
            baud_d    = '0;
            bit_d     = 3'd0;
            byte_d    = 3'd0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
          end
        end

        S_START: begin
          if (baud_end) begin
            baud_d  = '0;
            state_d = S_DATA;
            tx_d    = shift_q[0];
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_d = '0;
            if (bit_q == 3'd7) begin
              bit_d   = 3'd0;
              state_d = S_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = {1'b0, shift_q[7:1]};
              tx_d    = shift_q[1];
            end
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_end) begin
            baud_d = '0;
            if (byte_q < 3'd6) begin
              byte_d  = byte_q + 3'd1;
              shift_d = next_byte;
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              byte_d  = 3'd0;
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= 3'd0;
      byte_q    <= 3'd0;
      shift_q   <= 8'd0;
      payload_q <= 40'd0;
      chk_q     <= 8'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      payload_q <= payload_d;
      chk_q     <= chk_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_microgreen_uart_report_tx.sv
// Self-checking bench for microgreen_uart_report_tx at 4 clocks per bit:
// a line decoder feeds decoded bytes against an expected-byte queue.
module tb_microgreen_uart_report_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [39:0] payload;
  logic        tx;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [1:0]  dbg_state;

  microgreen_uart_report_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .payload  (payload),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [39:0] p, input logic [7:0] chk);
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 5; k++) exp_q.push_back(p[8*k +: 8]);
    exp_q.push_back(chk);
  endtask

  // ---------------- line decoder ----------------
  logic       m_active = 1'b0;
  int         m_cyc = 0;
  logic       m_ok = 1'b1;
  logic       m_bitval = 1'b1;
  logic [7:0] m_byte = 8'd0;

  // Called once per cycle before the edge; only cycles with ena=1 advance the line.
  task automatic mon_step();
    int b;
    int ph;
    logic [7:0] e;
    if (!rst_n) begin
      m_active = 1'b0;
      return;
    end
    if (!ena) return;
    if (!m_active) begin
      if (tx !== 1'b0) return;
      m_active = 1'b1;
      m_cyc    = 0;
      m_ok     = 1'b1;
      m_byte   = 8'd0;
    end
    b  = m_cyc / CPB;
    ph = m_cyc % CPB;
    if (ph == 0) begin
      m_bitval = tx;
      if (b >= 1 && b <= 8) m_byte[b-1] = tx;
    end else if (tx !== m_bitval) begin
      m_ok = 1'b0;
    end
    if (b == 0 && tx !== 1'b0) m_ok = 1'b0;
    if (b == 9 && tx !== 1'b1) m_ok = 1'b0;
    if (m_cyc == 10*CPB - 1) begin
      m_active = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {56'd0, m_byte}, 64'h1FF);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", {55'd0, m_ok, m_byte}, {55'd0, 1'b1, e});
      end
    end else begin
      m_cyc++;
    end
  endtask

  // ---------------- driver tasks ----------------
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   ovr_cnt  = 0;
  int   hist_idx = 0;
  logic tx_hist[0:299];

  task automatic tick();
    mon_step();
    @(posedge clk);
    #1;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (hist_idx < 300) begin
      tx_hist[hist_idx] = tx;
      hist_idx++;
    end
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    done_cnt = 0;
    ovr_cnt  = 0;
    hist_idx = 0;
  endtask

  task automatic pulse_start(input logic [39:0] p);
    start   = 1'b1;
    payload = p;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic run_frame(input logic [39:0] p, input logic [7:0] chk, input int exp_busy);
    push_exp(p, chk);
    clear_counts();
    pulse_start(p);
    wait_done(400);
    check("busy_cycles", busy_cnt, exp_busy);
    check("done_pulses", done_cnt, 1);
    check("busy_low_at_done", {63'd0, busy}, 64'd0);
    check("queue_drained", exp_q.size(), 0);
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic check_hist(input string name, input int lo, input int hi, input logic v);
    logic ok = 1'b1;
    for (int i = lo; i <= hi; i++) if (tx_hist[i] !== v) ok = 1'b0;
    check(name, {63'd0, ok}, 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [39:0] payload;
    logic [7:0]  chk;
  } vec_t;
  vec_t vecs[4];

  initial begin
    vecs[0] = '{payload: 40'h0504030201, chk: 8'h01};
    vecs[1] = '{payload: 40'hFFFFFFFFFF, chk: 8'hFF};
    vecs[2] = '{payload: 40'h0000000000, chk: 8'h00};
    vecs[3] = '{payload: 40'h123456789A, chk: 8'h92};

    rst_n   = 1'b0;
    ena     = 1'b1;
    start   = 1'b0;
    payload = 40'd0;
    tick();
    tick();
    check("rst_tx", {63'd0, tx}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].payload, vecs[i].chk, 70*CPB);
    end

    // Bit timing of the start of a frame
    run_frame(40'h0504030201, 8'h01, 70*CPB);
    check_hist("start_bit_low", 0, 3, 1'b0);
    check_hist("sync_bit0_high", 4, 7, 1'b1);
    check_hist("sync_bit1_low", 8, 11, 1'b0);
    check_hist("stop_bit_high", 36, 39, 1'b1);
    check_hist("next_start_low", 40, 43, 1'b0);

    // Overrun mid-frame, then back-to-back start in the done cycle
    push_exp(40'h0504030201, 8'h01);
    clear_counts();
    pulse_start(40'h0504030201);
    repeat (99) tick();
    start   = 1'b1;
    payload = 40'hDEADBEEF11;
    tick();
    start   = 1'b0;
    check("overrun_pulse", {63'd0, overrun}, 64'd1);
    tick();
    check("overrun_one_cycle", {63'd0, overrun}, 64'd0);
    wait_done(400);
    check("f1_busy_cycles", busy_cnt, 70*CPB);
    check("f1_overrun_count", ovr_cnt, 1);
    check("f1_queue_drained", exp_q.size(), 0);
    push_exp(40'hDEADBEEF11, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h11);
    clear_counts();
    pulse_start(40'hDEADBEEF11);
    check("b2b_tx_low", {63'd0, tx}, 64'd0);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done(400);
    check("f2_busy_cycles", busy_cnt, 70*CPB);
    check("f2_queue_drained", exp_q.size(), 0);
    clear_counts();
    repeat (20) tick();
    check("no_extra_frame", busy_cnt, 0);

    // ena low for 10 cycles inside data bit 0 of SYNC (a 1 bit)
    push_exp(40'h0504030201, 8'h01);
    clear_counts();
    pulse_start(40'h0504030201);
    repeat (5) tick();
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ena_hold_tx", {63'd0, tx}, 64'd1);
    end
    check("ena_hold_busy", {63'd0, busy}, 64'd1);
    ena = 1'b1;
    wait_done(400);
    check("ena_busy_cycles", busy_cnt, 70*CPB + 10);
    check("ena_queue_drained", exp_q.size(), 0);
    tick();

    // Asynchronous reset during byte 3, then a clean frame
    push_exp(40'h0504030201, 8'h01);
    clear_counts();
    pulse_start(40'h0504030201);
    repeat (130) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", {63'd0, tx}, 64'd1);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_state", {62'd0, dbg_state}, 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(40'hA1B2C3D4E5, 8'hE5 ^ 8'hD4 ^ 8'hC3 ^ 8'hB2 ^ 8'hA1, 70*CPB);

    // Payload scrambled while the frame is in flight
    push_exp(40'h123456789A, 8'h92);
    clear_counts();
    pulse_start(40'h123456789A);
    for (int i = 0; i < 150; i++) begin
      payload = {$urandom_range(255, 0), $urandom()};
      tick();
    end
    wait_done(400);
    check("scramble_busy_cycles", busy_cnt, 70*CPB);
    check("scramble_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
